hpdcache_cfg_regs: RTL and testbench
====================================

Name: hpdcache_cfg_regs

Overview:
- Runtime configuration register bank for the HPDcache. It makes settings that are elaboration-time constants today programmable at run time.
- Software accesses it through a simple valid/ready register port. Writes land in shadow registers.
- An APPLY command drains the cache, waits for quiescence, then atomically commits shadow to active. Active values drive the cache's cfg_* inputs.
- Sits beside the hpdcache top, between the core CSR/MMIO path and the cache.

Parameters:
- NREQUESTERS, 4, number of requester ports; width of the requester enable mask.
- WBUF_TIMECNT_WIDTH, 4, width of the write-buffer timeout threshold field.
- ADDR_WIDTH, 4, register word-address width (8-byte words).
- DRAIN_TIMEOUT, 1024, maximum cycles the block waits for cache_idle_i before aborting an apply; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cfg_req_valid_i  in  1  register request valid
- cfg_req_ready_o  out  1  register request ready
- cfg_req_we_i  in  1  1=write, 0=read
- cfg_req_addr_i  in  ADDR_WIDTH  register word address
- cfg_req_wdata_i  in  64  write data
- cfg_req_be_i  in  8  write byte enables
- cfg_rsp_valid_o  out  1  response valid
- cfg_rsp_ready_i  in  1  response ready
- cfg_rsp_rdata_o  out  64  read data; 0 for writes
- cfg_rsp_error_o  out  1  access error
- cache_idle_i  in  1  cache has no pending miss, writeback or replay
- cfg_drain_req_o  out  1  request the cache to stop accepting new requests
- cfg_updated_o  out  1  one-cycle pulse when a commit occurs
- cfg_enable_o  out  1  active cache enable
- cfg_wbuf_reset_timecnt_on_write_o  out  1  active value of the corresponding cache setting
- cfg_wbuf_sequential_waw_o  out  1  active value of the corresponding cache setting
- cfg_rtab_single_entry_o  out  1  active value of the corresponding cache setting
- cfg_wbuf_threshold_o  out  WBUF_TIMECNT_WIDTH  active write-buffer timeout threshold
- cfg_req_enable_o  out  NREQUESTERS  active per-requester enable mask
- hit_i, miss_i  in  1 each  event pulses (used only with the optional feature)

Behaviour:
- Register map (word address):
  - 0 CTRL: bit0 enable, bit1 wbuf_reset_timecnt_on_write, bit2 wbuf_sequential_waw, bit3 rtab_single_entry.
  - 1 WBUF_THR: [WBUF_TIMECNT_WIDTH-1:0].
  - 2 REQ_MASK: [NREQUESTERS-1:0].
  - 3 APPLY/STATUS: write bit0=1 starts an apply; write bit1=1 clears the timeout flag. Read bit0=busy, bit1=timeout (sticky).
  - 4 HIT_CNT, 5 MISS_CNT: present only with the optional feature.
- Reads of addresses 0–2 return shadow values. Unimplemented bits are ignored on write and read as 0.
- Writes are per-byte under cfg_req_be_i.
- Unmapped address: write has no effect, read returns 0; both give cfg_rsp_error_o=1.
- Handshake:
  - cfg_req_ready_o = !cfg_rsp_valid_o || cfg_rsp_ready_i.
  - A request is accepted on valid&&ready. The response is registered and valid the next cycle.
  - The response is held stable until cfg_rsp_ready_i.
- Reset values:
  - Active and shadow: CTRL=4'b0110, WBUF_THR=3, REQ_MASK=all ones.
  - All outputs 0 except the active cfg_* values above.
  - FSM in IDLE; timeout flag 0.
- FSM states IDLE, DRAIN, COMMIT:
  - IDLE: APPLY write → DRAIN; the drain counter loads 0.
  - DRAIN: cfg_drain_req_o=1; the counter increments each cycle.
    - cache_idle_i=1 → COMMIT.
    - Else counter==DRAIN_TIMEOUT-1 → IDLE, set timeout, no commit.
    - If idle and timeout occur in the same cycle, idle wins.
  - COMMIT: one cycle; cfg_drain_req_o=1; active ← shadow; cfg_updated_o=1; next IDLE.
  - Active outputs change in the cycle after COMMIT.
- In DRAIN or COMMIT (busy):
  - Writes to addresses 0–3 have no effect and return error=1.
  - Reads are serviced normally.
- An APPLY write while IDLE, in the same cycle as a timeout clear, performs both.
- Reset asserted mid-apply returns to IDLE, restores reset values, drops cfg_drain_req_o the next cycle and drops any pending response.

Optional Feature:
- Macro: HPDCACHE_CFG_PERF_CNT_EN.
- When defined:
  - Two 32-bit counters count hit_i and miss_i pulses, saturating at 0xFFFF_FFFF. They read as zero-extended 64-bit values at addresses 4/5.
  - Any write to a counter clears it. Clear wins over a same-cycle increment.
  - Counters reset to 0.
- When undefined:
  - No counters are built; addresses 4/5 are unmapped (error=1).
  - hit_i and miss_i are ignored.

Decomposition:
- Shared package hpdcache_cfg_pkg holds:
  - register address localparams;
  - CTRL bit-index constants;
  - reset-value constants;
  - FSM state enum;
  - a packed struct hpdcache_cfg_t holding all active fields.
- One natural sub-module, hpdcache_cfg_apply_fsm: drain/commit FSM plus timeout counter.

Test Plan:
- Reset: after rst_i, read addr 0 → rdata=0x6, error=0; cfg_enable_o=0; cfg_wbuf_threshold_o=3; cfg_req_enable_o=4'hF.
- Staged write: write CTRL=0x1, then read addr 0 → 0x1, while cfg_enable_o stays 0. Write APPLY=1 with cache_idle_i=1 after 5 cycles → cfg_drain_req_o high for 6 cycles, cfg_updated_o pulses once, cfg_enable_o=1.
- Timeout: DRAIN_TIMEOUT=16, cache_idle_i held 0, APPLY → IDLE after 16 cycles. STATUS reads 0x2, active values are unchanged, and no cfg_updated_o pulse. Write APPLY=0x2 → STATUS reads 0.
- Busy write rejection: during DRAIN, write WBUF_THR=5 → error=1, and a shadow read returns the old value 3.
- Backpressure: hold cfg_rsp_ready_i=0 for 3 cycles → response stable, cfg_req_ready_o=0, and a second request is not accepted until release. Byte enable be=0x01 with wdata=0xFF on REQ_MASK → shadow=0xF.
- Feature: with HPDCACHE_CFG_PERF_CNT_EN, 7 hit_i pulses → addr 4 reads 7. Writing addr 4 in the same cycle as a hit_i pulse → 0. Without the macro, reading addr 4 → error=1.

Source files
------------

// File: rtl/hpdcache_cfg_pkg.sv
// hpdcache_cfg_pkg: shared register map, reset values, apply-FSM encoding and the
// active-configuration struct for the HPDcache runtime configuration bank.
package hpdcache_cfg_pkg;

    // Field widths of the configuration struct; the bank's parameters default to these
    localparam int unsigned HPDCACHE_CFG_NREQUESTERS        = 4;
    localparam int unsigned HPDCACHE_CFG_WBUF_TIMECNT_WIDTH = 4;

    localparam int unsigned CFG_ADDR_CTRL     = 0;
    localparam int unsigned CFG_ADDR_WBUF_THR = 1;
    localparam int unsigned CFG_ADDR_REQ_MASK = 2;
    localparam int unsigned CFG_ADDR_APPLY    = 3;
    localparam int unsigned CFG_ADDR_HIT_CNT  = 4;
    localparam int unsigned CFG_ADDR_MISS_CNT = 5;

    localparam int unsigned CTRL_ENABLE_BIT         = 0;
    localparam int unsigned CTRL_RESET_TIMECNT_BIT  = 1;
    localparam int unsigned CTRL_SEQUENTIAL_WAW_BIT = 2;
    localparam int unsigned CTRL_RTAB_SINGLE_BIT    = 3;

    localparam int unsigned APPLY_START_BIT       = 0;
    localparam int unsigned APPLY_CLR_TIMEOUT_BIT = 1;

    localparam logic [3:0] CFG_CTRL_RESET = 4'b0110;
    localparam logic [HPDCACHE_CFG_WBUF_TIMECNT_WIDTH-1:0] CFG_WBUF_THR_RESET =
        HPDCACHE_CFG_WBUF_TIMECNT_WIDTH'(32'd3);
    localparam logic [HPDCACHE_CFG_NREQUESTERS-1:0] CFG_REQ_MASK_RESET = '1;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'b00,
        CFG_DRAIN  = 2'b01,
        CFG_COMMIT = 2'b10
    } hpdcache_cfg_state_e;

    typedef struct packed {
        logic                                       enable;
        logic                                       wbuf_reset_timecnt_on_write;
        logic                                       wbuf_sequential_waw;
        logic                                       rtab_single_entry;
        logic [HPDCACHE_CFG_WBUF_TIMECNT_WIDTH-1:0] wbuf_threshold;
        logic [HPDCACHE_CFG_NREQUESTERS-1:0]        req_enable;
    } hpdcache_cfg_t;

    localparam hpdcache_cfg_t HPDCACHE_CFG_RESET = '{
        enable:                      CFG_CTRL_RESET[CTRL_ENABLE_BIT],
        wbuf_reset_timecnt_on_write: CFG_CTRL_RESET[CTRL_RESET_TIMECNT_BIT],
        wbuf_sequential_waw:         CFG_CTRL_RESET[CTRL_SEQUENTIAL_WAW_BIT],
        rtab_single_entry:           CFG_CTRL_RESET[CTRL_RTAB_SINGLE_BIT],
        wbuf_threshold:              CFG_WBUF_THR_RESET,
        req_enable:                  CFG_REQ_MASK_RESET
    };

    // Expand byte enables into a 64-bit bit mask
    function automatic logic [63:0] cfg_be_to_mask(input logic [7:0] be);
        return {{8{be[7]}}, {8{be[6]}}, {8{be[5]}}, {8{be[4]}},
                {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/hpdcache_cfg_apply_fsm.sv
// hpdcache_cfg_apply_fsm: drain -> wait-for-idle -> commit sequencer with a bounded
// drain window and a sticky timeout flag.
module hpdcache_cfg_apply_fsm
    import hpdcache_cfg_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic apply_i,
    input  logic timeout_clr_i,
    input  logic cache_idle_i,
    output logic busy_o,
    output logic timeout_o,
    output logic drain_req_o,
    output logic commit_o
);

    localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    hpdcache_cfg_state_e state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                timeout_r, timeout_set_s;
    logic                drain_req_r, drain_req_nxt_s;
    logic                commit_r, commit_nxt_s;

    // State and drain counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= CFG_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state: idle wins over a timeout landing in the same cycle
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        timeout_set_s = 1'b0;
        case (state_r)
            CFG_IDLE: begin
                if (apply_i) begin
                    state_nxt_s = CFG_DRAIN;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = CFG_IDLE;
                end
            end
            CFG_DRAIN: begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                if (cache_idle_i) begin
                    state_nxt_s = CFG_COMMIT;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = CFG_IDLE;
                    timeout_set_s = 1'b1;
                end else begin
                    state_nxt_s = CFG_DRAIN;
                end
            end
            CFG_COMMIT: begin
                state_nxt_s = CFG_IDLE;
            end
            default: begin
                state_nxt_s = CFG_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    always_comb begin
        drain_req_nxt_s = (state_nxt_s != CFG_IDLE);
        commit_nxt_s    = (state_nxt_s == CFG_COMMIT);
    end

    // Registered drain request and commit pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_req_r <= 1'b0;
            commit_r    <= 1'b0;
        end else begin
            drain_req_r <= drain_req_nxt_s;
            commit_r    <= commit_nxt_s;
        end
    end

    // Sticky timeout flag, cleared only by software
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_r <= 1'b0;
        end else if (timeout_set_s) begin
            timeout_r <= 1'b1;
        end else if (timeout_clr_i) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign busy_o      = (state_r != CFG_IDLE);
    assign timeout_o   = timeout_r;
    assign drain_req_o = drain_req_r;
    assign commit_o    = commit_r;

endmodule

// File: rtl/hpdcache_cfg_regs.sv
// hpdcache_cfg_regs: runtime HPDcache configuration bank; software writes shadow registers,
// APPLY drains the cache and commits them to active. HPDCACHE_CFG_PERF_CNT_EN adds hit/miss counters.
module hpdcache_cfg_regs
    import hpdcache_cfg_pkg::*;
#(
    parameter int unsigned NREQUESTERS        = HPDCACHE_CFG_NREQUESTERS,
    parameter int unsigned WBUF_TIMECNT_WIDTH = HPDCACHE_CFG_WBUF_TIMECNT_WIDTH,
    parameter int unsigned ADDR_WIDTH         = 4,
    parameter int unsigned DRAIN_TIMEOUT      = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_req_valid_i,
    output logic                          cfg_req_ready_o,
    input  logic                          cfg_req_we_i,
    input  logic [ADDR_WIDTH-1:0]         cfg_req_addr_i,
    input  logic [63:0]                   cfg_req_wdata_i,
    input  logic [7:0]                    cfg_req_be_i,
    output logic                          cfg_rsp_valid_o,
    input  logic                          cfg_rsp_ready_i,
    output logic [63:0]                   cfg_rsp_rdata_o,
    output logic                          cfg_rsp_error_o,
    input  logic                          cache_idle_i,
    output logic                          cfg_drain_req_o,
    output logic                          cfg_updated_o,
    output logic                          cfg_enable_o,
    output logic                          cfg_wbuf_reset_timecnt_on_write_o,
    output logic                          cfg_wbuf_sequential_waw_o,
    output logic                          cfg_rtab_single_entry_o,
    output logic [WBUF_TIMECNT_WIDTH-1:0] cfg_wbuf_threshold_o,
    output logic [NREQUESTERS-1:0]        cfg_req_enable_o,
    input  logic                          hit_i,
    input  logic                          miss_i
);

    hpdcache_cfg_t shadow_r, shadow_nxt_s, active_r;
    logic          rsp_valid_r, rsp_error_r;
    logic [63:0]   rsp_rdata_r;
    logic          accept_s, wr_s, wr_cfg_s, busy_s, timeout_s, commit_s;
    logic          apply_s, timeout_clr_s;
    logic [63:0]   be_mask_s, rd_data_s;
    logic          rd_mapped_s, rsp_error_s;
    logic [3:0]    ctrl_s, ctrl_nxt_s;
    logic          unused_s;

    assign cfg_req_ready_o = !rsp_valid_r || cfg_rsp_ready_i;
    assign accept_s        = cfg_req_valid_i && cfg_req_ready_o;
    assign wr_s            = accept_s && cfg_req_we_i;
    assign wr_cfg_s        = wr_s && !busy_s;
    assign be_mask_s       = cfg_be_to_mask(cfg_req_be_i);
    assign apply_s         = wr_cfg_s && (cfg_req_addr_i == ADDR_WIDTH'(CFG_ADDR_APPLY)) &&
                             cfg_req_wdata_i[APPLY_START_BIT] && cfg_req_be_i[0];
    assign timeout_clr_s   = wr_cfg_s && (cfg_req_addr_i == ADDR_WIDTH'(CFG_ADDR_APPLY)) &&
                             cfg_req_wdata_i[APPLY_CLR_TIMEOUT_BIT] && cfg_req_be_i[0];

    hpdcache_cfg_apply_fsm #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) i_apply_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .apply_i       (apply_s),
        .timeout_clr_i (timeout_clr_s),
        .cache_idle_i  (cache_idle_i),
        .busy_o        (busy_s),
        .timeout_o     (timeout_s),
        .drain_req_o   (cfg_drain_req_o),
        .commit_o      (commit_s)
    );

`ifdef HPDCACHE_CFG_PERF_CNT_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating event counters; a write to the counter's address clears it first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (wr_s && (cfg_req_addr_i == ADDR_WIDTH'(CFG_ADDR_HIT_CNT))) begin
                hit_cnt_r <= 32'd0;
            end else if (hit_i && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end
            if (wr_s && (cfg_req_addr_i == ADDR_WIDTH'(CFG_ADDR_MISS_CNT))) begin
                miss_cnt_r <= 32'd0;
            end else if (miss_i && (miss_cnt_r != 32'hFFFF_FFFF)) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign unused_s = ^{be_mask_s, cfg_req_wdata_i};
`else
    assign unused_s = ^{be_mask_s, cfg_req_wdata_i, hit_i, miss_i};
`endif

    // CTRL bits gathered into register layout
    always_comb begin
        ctrl_s                          = 4'b0000;
        ctrl_s[CTRL_ENABLE_BIT]         = shadow_r.enable;
        ctrl_s[CTRL_RESET_TIMECNT_BIT]  = shadow_r.wbuf_reset_timecnt_on_write;
        ctrl_s[CTRL_SEQUENTIAL_WAW_BIT] = shadow_r.wbuf_sequential_waw;
        ctrl_s[CTRL_RTAB_SINGLE_BIT]    = shadow_r.rtab_single_entry;
        ctrl_nxt_s = (ctrl_s & ~be_mask_s[3:0]) | (cfg_req_wdata_i[3:0] & be_mask_s[3:0]);
    end

    // Byte-masked shadow update; writes are dropped while an apply is in flight
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (wr_cfg_s) begin
            case (cfg_req_addr_i)
                ADDR_WIDTH'(CFG_ADDR_CTRL): begin
                    shadow_nxt_s.enable                      = ctrl_nxt_s[CTRL_ENABLE_BIT];
                    shadow_nxt_s.wbuf_reset_timecnt_on_write = ctrl_nxt_s[CTRL_RESET_TIMECNT_BIT];
                    shadow_nxt_s.wbuf_sequential_waw         = ctrl_nxt_s[CTRL_SEQUENTIAL_WAW_BIT];
                    shadow_nxt_s.rtab_single_entry           = ctrl_nxt_s[CTRL_RTAB_SINGLE_BIT];
                end
                ADDR_WIDTH'(CFG_ADDR_WBUF_THR): begin
                    shadow_nxt_s.wbuf_threshold =
                        (shadow_r.wbuf_threshold & ~be_mask_s[WBUF_TIMECNT_WIDTH-1:0]) |
                        (cfg_req_wdata_i[WBUF_TIMECNT_WIDTH-1:0] & be_mask_s[WBUF_TIMECNT_WIDTH-1:0]);
                end
                ADDR_WIDTH'(CFG_ADDR_REQ_MASK): begin
                    shadow_nxt_s.req_enable =
                        (shadow_r.req_enable & ~be_mask_s[NREQUESTERS-1:0]) |
                        (cfg_req_wdata_i[NREQUESTERS-1:0] & be_mask_s[NREQUESTERS-1:0]);
                end
                default: begin
                    shadow_nxt_s = shadow_r;
                end
            endcase
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Read mux and error decode for the request being accepted
    always_comb begin
        rd_data_s   = 64'd0;
        rd_mapped_s = 1'b1;
        case (cfg_req_addr_i)
            ADDR_WIDTH'(CFG_ADDR_CTRL):     rd_data_s = 64'(ctrl_s);
            ADDR_WIDTH'(CFG_ADDR_WBUF_THR): rd_data_s = 64'(shadow_r.wbuf_threshold);
            ADDR_WIDTH'(CFG_ADDR_REQ_MASK): rd_data_s = 64'(shadow_r.req_enable);
            ADDR_WIDTH'(CFG_ADDR_APPLY):    rd_data_s = {62'd0, timeout_s, busy_s};
`ifdef HPDCACHE_CFG_PERF_CNT_EN
            ADDR_WIDTH'(CFG_ADDR_HIT_CNT):  rd_data_s = 64'(hit_cnt_r);
            ADDR_WIDTH'(CFG_ADDR_MISS_CNT): rd_data_s = 64'(miss_cnt_r);
`endif
            default: begin
                rd_data_s   = 64'd0;
                rd_mapped_s = 1'b0;
            end
        endcase
        rsp_error_s = !rd_mapped_s ||
                      (cfg_req_we_i && busy_s && (cfg_req_addr_i <= ADDR_WIDTH'(CFG_ADDR_APPLY)));
    end

    // Shadow and active configuration registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_r <= HPDCACHE_CFG_RESET;
            active_r <= HPDCACHE_CFG_RESET;
        end else begin
            shadow_r <= shadow_nxt_s;
            if (commit_s) begin
                active_r <= shadow_r;
            end else begin
                active_r <= active_r;
            end
        end
    end

    // Response register: loads on accept, held until the requester takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 64'd0;
            rsp_error_r <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= cfg_req_we_i ? 64'd0 : rd_data_s;
            rsp_error_r <= rsp_error_s;
        end else if (cfg_rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_error_r <= rsp_error_r;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_error_r <= rsp_error_r;
        end
    end

    assign cfg_updated_o                     = commit_s;
    assign cfg_rsp_valid_o                   = rsp_valid_r;
    assign cfg_rsp_rdata_o                   = rsp_rdata_r;
    assign cfg_rsp_error_o                   = rsp_error_r;
    assign cfg_enable_o                      = active_r.enable;
    assign cfg_wbuf_reset_timecnt_on_write_o = active_r.wbuf_reset_timecnt_on_write;
    assign cfg_wbuf_sequential_waw_o         = active_r.wbuf_sequential_waw;
    assign cfg_rtab_single_entry_o           = active_r.rtab_single_entry;
    assign cfg_wbuf_threshold_o              = active_r.wbuf_threshold;
    assign cfg_req_enable_o                  = active_r.req_enable;

endmodule

// File: tb/tb_hpdcache_cfg_regs.sv
// tb_hpdcache_cfg_regs: scoreboard bench for the HPDcache configuration bank
// (staged writes, apply/commit, drain timeout, busy rejection, backpressure, byte enables).
module tb_hpdcache_cfg_regs;

    localparam int unsigned DT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [3:0]  req_addr = 4'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_be = 8'h00;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
    logic [63:0] rsp_rdata;
    logic        cache_idle = 1'b0, drain_req, updated;
    logic        en, rst_tc, seq_waw, rtab_single;
    logic [3:0]  thr, req_en;
    logic        hit = 1'b0, miss = 1'b0;

    int          tests_run = 0, tests_failed = 0;
    int          drain_cycles = 0, upd_pulses = 0;
    int          d0, u0;
    logic [64:0] exp_q[$];

    hpdcache_cfg_regs #(.DRAIN_TIMEOUT(DT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_valid_i(req_valid), .cfg_req_ready_o(req_ready), .cfg_req_we_i(req_we),
        .cfg_req_addr_i(req_addr), .cfg_req_wdata_i(req_wdata), .cfg_req_be_i(req_be),
        .cfg_rsp_valid_o(rsp_valid), .cfg_rsp_ready_i(rsp_ready),
        .cfg_rsp_rdata_o(rsp_rdata), .cfg_rsp_error_o(rsp_error),
        .cache_idle_i(cache_idle), .cfg_drain_req_o(drain_req), .cfg_updated_o(updated),
        .cfg_enable_o(en), .cfg_wbuf_reset_timecnt_on_write_o(rst_tc),
        .cfg_wbuf_sequential_waw_o(seq_waw), .cfg_rtab_single_entry_o(rtab_single),
        .cfg_wbuf_threshold_o(thr), .cfg_req_enable_o(req_en),
        .hit_i(hit), .miss_i(miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every response handshake, plus drain/update activity counts
    always @(negedge clk) begin : mon
        logic [64:0] e;
        if (drain_req) drain_cycles++;
        if (updated) upd_pulses++;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_error", 64'(rsp_error), 64'(e[64]));
                chk("rsp_rdata", rsp_rdata, e[63:0]);
            end
        end
    end

    task automatic cfg_access(input logic we, input logic [3:0] addr, input logic [63:0] wdata,
                              input logic [7:0] be, input logic [63:0] exp_rdata,
                              input logic exp_err);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        if (n >= 50) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back({exp_err, exp_rdata});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_drain", 64'(drain_req), 64'd0);
        chk("rst_updated", 64'(updated), 64'd0);
        chk("rst_enable", 64'(en), 64'd0);
        chk("rst_ctrl_bits", 64'({rtab_single, seq_waw, rst_tc}), 64'h3);
        chk("rst_thr", 64'(thr), 64'd3);
        chk("rst_req_en", 64'(req_en), 64'hF);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        cfg_access(1'b0, 4'd0, 64'd0, 8'h00, 64'h6, 1'b0);
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h0, 1'b0);

        // Staged write does not reach the active outputs
        cfg_access(1'b1, 4'd0, 64'h1, 8'hFF, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd0, 64'd0, 8'h00, 64'h1, 1'b0);
        wait_rsp();
        chk("staged_enable", 64'(en), 64'd0);

        // Apply: idle arrives after 5 drain cycles, commit follows
        d0 = drain_cycles; u0 = upd_pulses;
        cfg_access(1'b1, 4'd3, 64'h1, 8'hFF, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1 cache_idle = 1'b1;
        repeat (4) @(posedge clk);
        #1 cache_idle = 1'b0;
        @(negedge clk);
        chk("apply_drain_cycles", 64'(drain_cycles - d0), 64'd6);
        chk("apply_upd_pulses", 64'(upd_pulses - u0), 64'd1);
        chk("apply_enable", 64'(en), 64'd1);
        chk("apply_ctrl_bits", 64'({rtab_single, seq_waw, rst_tc}), 64'h0);
        wait_rsp();

        // Timeout with busy-phase accesses
        d0 = drain_cycles; u0 = upd_pulses;
        cfg_access(1'b1, 4'd3, 64'h1, 8'hFF, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h1, 1'b0);
        cfg_access(1'b1, 4'd1, 64'h5, 8'hFF, 64'h0, 1'b1);
        cfg_access(1'b0, 4'd1, 64'd0, 8'h00, 64'h3, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("timeout_drain_cycles", 64'(drain_cycles - d0), 64'(DT));
        chk("timeout_upd_pulses", 64'(upd_pulses - u0), 64'd0);
        chk("timeout_enable", 64'(en), 64'd1);
        chk("timeout_thr", 64'(thr), 64'd3);
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h2, 1'b0);
        cfg_access(1'b1, 4'd3, 64'h2, 8'hFF, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h0, 1'b0);
        wait_rsp();

        // Backpressure: response held, no second accept until release
        @(posedge clk); #1 rsp_ready = 1'b0;
        cfg_access(1'b0, 4'd1, 64'd0, 8'h00, 64'h3, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; req_be = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_rdata", rsp_rdata, 64'h3);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 64'h1});
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp();

        // Byte enables on REQ_MASK
        cfg_access(1'b1, 4'd2, 64'h0, 8'hFF, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd2, 64'd0, 8'h00, 64'h0, 1'b0);
        cfg_access(1'b1, 4'd2, 64'hFF, 8'h01, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd2, 64'd0, 8'h00, 64'hF, 1'b0);
        cfg_access(1'b1, 4'd2, 64'h0, 8'hFE, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd2, 64'd0, 8'h00, 64'hF, 1'b0);
        cfg_access(1'b1, 4'd1, 64'hFFFF_FFFF_FFFF_FF07, 8'hFF, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd1, 64'd0, 8'h00, 64'h7, 1'b0);

        // Unmapped addresses
        cfg_access(1'b0, 4'd7, 64'd0, 8'h00, 64'h0, 1'b1);
        cfg_access(1'b1, 4'd9, 64'hFF, 8'hFF, 64'h0, 1'b1);
        wait_rsp();

        // Event counters (or their absence)
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1 hit = 1'b1;
            @(posedge clk); #1 hit = 1'b0;
        end
`ifdef HPDCACHE_CFG_PERF_CNT_EN
        cfg_access(1'b0, 4'd4, 64'd0, 8'h00, 64'd7, 1'b0);
        cfg_access(1'b0, 4'd5, 64'd0, 8'h00, 64'd0, 1'b0);
        wait_rsp();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 64'd0; req_be = 8'hFF;
        hit = 1'b1;
        exp_q.push_back({1'b0, 64'd0});
        @(posedge clk); #1;
        req_valid = 1'b0; hit = 1'b0;
        cfg_access(1'b0, 4'd4, 64'd0, 8'h00, 64'd0, 1'b0);
`else
        cfg_access(1'b0, 4'd4, 64'd0, 8'h00, 64'd0, 1'b1);
        cfg_access(1'b0, 4'd5, 64'd0, 8'h00, 64'd0, 1'b1);
`endif
        wait_rsp();

        // Reset in the middle of an apply drops state and the pending response
        cache_idle = 1'b0;
        cfg_access(1'b1, 4'd3, 64'h1, 8'hFF, 64'h0, 1'b0);
        wait_rsp();
        @(posedge clk); #1 rsp_ready = 1'b0;
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_drain", 64'(drain_req), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_enable", 64'(en), 64'd0);
        chk("mid_rst_thr", 64'(thr), 64'd3);
        cfg_access(1'b0, 4'd3, 64'd0, 8'h00, 64'h0, 1'b0);
        cfg_access(1'b0, 4'd1, 64'd0, 8'h00, 64'h3, 1'b0);
        wait_rsp();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
